// File: rtl/mem_fill_ctrl.sv
// MEM_FILL sequencer: writes one 16-bit value to a run of SDRAM words,
// split into bursts that never cross a MAX_BURST-aligned boundary.
module mem_fill_ctrl #(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fill_trigger_i,
    input  logic [15:0]       fill_base_i,
    input  logic [15:0]       fill_value_i,
    input  logic [19:0]       fill_count_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_len_o,
    input  logic              mem_ack_i,
    output logic [15:0]       mem_wdata_o,
    input  logic              mem_wdata_rdy_i,
    input  logic              mem_burst_done_i
);

    localparam int LOG_B = $clog2(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DATA,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [19:0]       rem_q, rem_d;
    logic [15:0]       val_q, val_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mlen_q, mlen_d;
    logic [15:0]       mwdata_q, mwdata_d;
    logic [7:0]        beat_q, beat_d;
    logic              zdone_q, zdone_d;

    logic [8:0] room;
    logic [7:0] burst_len;
    logic       start_fill;
    logic       last_burst;

    // Words left before the next MAX_BURST-aligned boundary.
    assign room       = 9'(MAX_BURST) - 9'(addr_q[LOG_B-1:0]);
    assign burst_len  = (rem_q < 20'(room)) ? rem_q[7:0] : room[7:0];
    assign start_fill = fill_trigger_i && (fill_count_i != '0);
    assign last_burst = (rem_q == 20'(mlen_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            val_q    <= '0;
            maddr_q  <= '0;
            mlen_q   <= '0;
            mwdata_q <= '0;
            beat_q   <= '0;
            zdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            val_q    <= val_d;
            maddr_q  <= maddr_d;
            mlen_q   <= mlen_d;
            mwdata_q <= mwdata_d;
            beat_q   <= beat_d;
            zdone_q  <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_fill) state_d = S_CALC;
            S_CALC: state_d = S_REQ;
            S_REQ:  if (mem_ack_i) state_d = S_DATA;
            S_DATA: begin
                if (mem_burst_done_i) begin
                    state_d = last_burst ? S_DONE : S_CALC;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        rem_d    = rem_q;
        val_d    = val_q;
        maddr_d  = maddr_q;
        mlen_d   = mlen_q;
        mwdata_d = mwdata_q;
        beat_d   = beat_q;
        zdone_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                zdone_d = fill_trigger_i && (fill_count_i == '0);
                if (start_fill) begin
                    addr_d = ADDR_W'({fill_base_i, 8'h00});
                    val_d  = fill_value_i;
                    rem_d  = fill_count_i;
                end
            end
            S_CALC: begin
                maddr_d  = addr_q;
                mlen_d   = burst_len;
                mwdata_d = val_q;
                beat_d   = burst_len;
            end
            S_DATA: begin
                // Surplus rdy strobes past the burst length are dropped.
                if (mem_wdata_rdy_i && beat_q != '0) begin
                    beat_d = beat_q - 8'd1;
                end
                if (mem_burst_done_i) begin
                    addr_d = addr_q + ADDR_W'(mlen_q);
                    rem_d  = rem_q - 20'(mlen_q);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fill_busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
        fill_done_o = (state_q == S_DONE) || zdone_q;
        mem_req_o   = (state_q == S_REQ);
        mem_addr_o  = maddr_q;
        mem_len_o   = mlen_q;
        mem_wdata_o = mwdata_q;
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Directed bench for mem_fill_ctrl with a small arbiter responder.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mem_fill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fill_trigger_i;
    logic [15:0] fill_base_i;
    logic [15:0] fill_value_i;
    logic [19:0] fill_count_i;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_len_o;
    logic        mem_ack_i;
    logic [15:0] mem_wdata_o;
    logic        mem_wdata_rdy_i;
    logic        mem_burst_done_i;

    mem_fill_ctrl #(.MAX_BURST(16), .ADDR_W(24)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .fill_trigger_i   (fill_trigger_i),
        .fill_base_i      (fill_base_i),
        .fill_value_i     (fill_value_i),
        .fill_count_i     (fill_count_i),
        .fill_busy_o      (fill_busy_o),
        .fill_done_o      (fill_done_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_len_o        (mem_len_o),
        .mem_ack_i        (mem_ack_i),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wdata_rdy_i  (mem_wdata_rdy_i),
        .mem_burst_done_i (mem_burst_done_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [23:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    int r_words, r_dones, r_busy_bad, r_wdata_bad, r_stab_bad;
    bit r_timeout;

    task automatic idle_inputs();
        fill_trigger_i   = 1'b0;
        fill_base_i      = '0;
        fill_value_i     = '0;
        fill_count_i     = '0;
        mem_ack_i        = 1'b0;
        mem_wdata_rdy_i  = 1'b0;
        mem_burst_done_i = 1'b0;
    endtask

    // Trigger a fill, then act as the arbiter until fill_done.
    task automatic do_fill(input logic [15:0] base, input logic [15:0] val,
                           input logic [19:0] cnt, input int ack_wait,
                           input bit retrig);
        int ph, left, hold;
        bit fired, done_seen;
        logic [23:0] cur_a;
        logic [7:0]  cur_l;
        bq_addr.delete();
        bq_len.delete();
        r_words = 0; r_dones = 0; r_busy_bad = 0;
        r_wdata_bad = 0; r_stab_bad = 0; r_timeout = 0;
        ph = 0; left = 0; hold = 0; fired = 0; done_seen = 0;
        cur_a = '0; cur_l = '0;
        @(negedge clk_i);
        fill_trigger_i = 1'b1;
        fill_base_i    = base;
        fill_value_i   = val;
        fill_count_i   = cnt;
        @(negedge clk_i);
        fill_trigger_i = 1'b0;
        fill_base_i    = 16'h7777;
        fill_value_i   = 16'hDEAD;
        fill_count_i   = 20'd3;
        for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            fill_trigger_i = 1'b0;
            if (fill_done_o) begin
                r_dones++;
                done_seen = 1;
                if (fill_busy_o) r_busy_bad++;
            end else if (!fill_busy_o) begin
                r_busy_bad++;
            end
            case (ph)
                0: if (mem_req_o) begin
                    cur_a = mem_addr_o;
                    cur_l = mem_len_o;
                    bq_addr.push_back(cur_a);
                    bq_len.push_back(cur_l);
                    hold = 0;
                    if (ack_wait == 0) begin
                        mem_ack_i = 1'b1;
                        ph = 2;
                    end else begin
                        ph = 1;
                    end
                end
                1: begin
                    if (!mem_req_o || mem_addr_o !== cur_a ||
                        mem_len_o !== cur_l) r_stab_bad++;
                    hold++;
                    if (hold >= ack_wait) begin
                        mem_ack_i = 1'b1;
                        ph = 2;
                    end
                end
                2: begin
                    mem_ack_i = 1'b0;
                    if (mem_req_o) r_stab_bad++;
                    if (mem_wdata_o !== val) r_wdata_bad++;
                    left = int'(cur_l) - 1;
                    r_words++;
                    mem_wdata_rdy_i  = 1'b1;
                    mem_burst_done_i = (left == 0);
                    ph = 3;
                    if (retrig && !fired) begin
                        fired          = 1;
                        fill_trigger_i = 1'b1;
                        fill_base_i    = 16'h0200;
                        fill_value_i   = 16'h1234;
                        fill_count_i   = 20'd100;
                    end
                end
                default: begin
                    if (left <= 0) begin
                        mem_wdata_rdy_i  = 1'b0;
                        mem_burst_done_i = 1'b0;
                        ph = 0;
                    end else begin
                        if (mem_wdata_o !== val) r_wdata_bad++;
                        r_words++;
                        left--;
                        mem_burst_done_i = (left == 0);
                    end
                end
            endcase
        end
        if (!done_seen) r_timeout = 1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (fill_done_o) r_dones++;
            if (fill_busy_o) r_busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({fill_busy_o, fill_done_o, mem_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000",
                     {fill_busy_o, fill_done_o, mem_req_o});
        end
        checks++;
        if ({mem_addr_o, mem_len_o, mem_wdata_o} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {mem_addr_o, mem_len_o, mem_wdata_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single_burst();
        do_fill(16'h0010, 16'hA5A5, 20'd16, 0, 0);
        checks++;
        if (r_timeout) begin errors++; $display("FAIL t1_timeout got 1 want 0"); end
        checks++;
        if (bq_addr.size() != 1) begin
            errors++; $display("FAIL t1_nbursts got %0d want 1", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 24'h001000 || bq_len[0] !== 8'd16) begin
                errors++;
                $display("FAIL t1_burst got %h/%0d want 001000/16", bq_addr[0], bq_len[0]);
            end
        end
        checks++;
        if (r_words != 16) begin errors++; $display("FAIL t1_words got %0d want 16", r_words); end
        checks++;
        if (r_wdata_bad != 0) begin errors++; $display("FAIL t1_wdata got %0d bad want 0", r_wdata_bad); end
        checks++;
        if (r_dones != 1) begin errors++; $display("FAIL t1_dones got %0d want 1", r_dones); end
        checks++;
        if (r_busy_bad != 0) begin errors++; $display("FAIL t1_busy got %0d bad want 0", r_busy_bad); end
    endtask

    task automatic test_multi_burst();
        do_fill(16'h0000, 16'h0F0F, 20'd40, 1, 0);
        checks++;
        if (r_timeout) begin errors++; $display("FAIL t2_timeout got 1 want 0"); end
        checks++;
        if (bq_addr.size() != 3) begin
            errors++; $display("FAIL t2_nbursts got %0d want 3", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 24'h000000 || bq_len[0] !== 8'd16 ||
                bq_addr[1] !== 24'h000010 || bq_len[1] !== 8'd16 ||
                bq_addr[2] !== 24'h000020 || bq_len[2] !== 8'd8) begin
                errors++;
                $display("FAIL t2_bursts got %h/%0d %h/%0d %h/%0d want 000000/16 000010/16 000020/8",
                         bq_addr[0], bq_len[0], bq_addr[1], bq_len[1], bq_addr[2], bq_len[2]);
            end
        end
        checks++;
        if (r_words != 40 || r_dones != 1) begin
            errors++; $display("FAIL t2_words_done got %0d/%0d want 40/1", r_words, r_dones);
        end
        checks++;
        if (r_stab_bad != 0) begin errors++; $display("FAIL t2_stable got %0d bad want 0", r_stab_bad); end
    endtask

    task automatic test_zero_count();
        int dones, reqs, busys, first;
        dones = 0; reqs = 0; busys = 0; first = -1;
        @(negedge clk_i);
        fill_trigger_i = 1'b1;
        fill_count_i   = 20'd0;
        fill_base_i    = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            fill_trigger_i = 1'b0;
            if (fill_done_o) begin
                dones++;
                if (first < 0) first = i;
            end
            if (mem_req_o) reqs++;
            if (fill_busy_o) busys++;
        end
        checks++;
        if (dones != 1 || first != 0) begin
            errors++; $display("FAIL t3_done got %0d at %0d want 1 at 0", dones, first);
        end
        checks++;
        if (reqs != 0 || busys != 0) begin
            errors++; $display("FAIL t3_quiet got req %0d busy %0d want 0 0", reqs, busys);
        end
    endtask

    task automatic test_retrigger();
        do_fill(16'h0003, 16'h3C3C, 20'd20, 0, 1);
        checks++;
        if (r_timeout) begin errors++; $display("FAIL t4_timeout got 1 want 0"); end
        checks++;
        if (r_words != 20 || r_dones != 1) begin
            errors++; $display("FAIL t4_words_done got %0d/%0d want 20/1", r_words, r_dones);
        end
        checks++;
        if (bq_addr.size() != 2) begin
            errors++; $display("FAIL t4_nbursts got %0d want 2", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[1] !== 24'h000310 || bq_len[1] !== 8'd4) begin
                errors++; $display("FAIL t4_burst2 got %h/%0d want 000310/4", bq_addr[1], bq_len[1]);
            end
        end
        checks++;
        if (r_wdata_bad != 0) begin errors++; $display("FAIL t4_wdata got %0d bad want 0", r_wdata_bad); end
    endtask

    task automatic test_wrap();
        do_fill(16'hFFFF, 16'h5555, 20'd300, 0, 0);
        checks++;
        if (r_timeout) begin errors++; $display("FAIL t5_timeout got 1 want 0"); end
        checks++;
        if (bq_addr.size() != 19) begin
            errors++; $display("FAIL t5_nbursts got %0d want 19", bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 24'hFFFF00 || bq_addr[15] !== 24'hFFFFF0 ||
                bq_addr[16] !== 24'h000000) begin
                errors++;
                $display("FAIL t5_wrap got %h %h %h want FFFF00 FFFFF0 000000",
                         bq_addr[0], bq_addr[15], bq_addr[16]);
            end
            checks++;
            if (bq_addr[18] !== 24'h000020 || bq_len[18] !== 8'd12) begin
                errors++; $display("FAIL t5_last got %h/%0d want 000020/12", bq_addr[18], bq_len[18]);
            end
        end
        checks++;
        if (r_words != 300 || r_dones != 1) begin
            errors++; $display("FAIL t5_words_done got %0d/%0d want 300/1", r_words, r_dones);
        end
    endtask

    task automatic test_reset_mid();
        int waited, stab_bad, dones, activity;
        bit got_req;
        logic [23:0] a0;
        logic [7:0]  l0;
        waited = 0; stab_bad = 0; dones = 0; activity = 0; got_req = 0;
        @(negedge clk_i);
        fill_trigger_i = 1'b1;
        fill_base_i    = 16'h0004;
        fill_value_i   = 16'hC3C3;
        fill_count_i   = 20'd40;
        @(negedge clk_i);
        fill_trigger_i = 1'b0;
        while (!got_req && waited < 20) begin
            @(negedge clk_i);
            waited++;
            got_req = mem_req_o;
        end
        checks++;
        if (!got_req) begin errors++; $display("FAIL t6_req got 0 want 1"); end
        a0 = mem_addr_o;
        l0 = mem_len_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (!mem_req_o || mem_addr_o !== a0 || mem_len_o !== l0) stab_bad++;
        end
        checks++;
        if (stab_bad != 0 || a0 !== 24'h000400 || l0 !== 8'd16) begin
            errors++;
            $display("FAIL t6_hold got %0d bad %h/%0d want 0 000400/16", stab_bad, a0, l0);
        end
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i       = 1'b0;
        mem_wdata_rdy_i = 1'b1;
        repeat (3) @(negedge clk_i);
        mem_wdata_rdy_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({fill_busy_o, fill_done_o, mem_req_o, mem_addr_o, mem_len_o, mem_wdata_o} !== 51'h0) begin
            errors++;
            $display("FAIL t6_rst_out got %h want 0",
                     {fill_busy_o, fill_done_o, mem_req_o, mem_addr_o, mem_len_o, mem_wdata_o});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (fill_done_o) dones++;
            if (fill_busy_o || mem_req_o) activity++;
        end
        checks++;
        if (dones != 0 || activity != 0) begin
            errors++; $display("FAIL t6_quiet got done %0d act %0d want 0 0", dones, activity);
        end
        do_fill(16'h0001, 16'h5A5A, 20'd5, 2, 0);
        checks++;
        if (r_timeout || bq_addr.size() != 1) begin
            errors++; $display("FAIL t6_restart got to %0d n %0d want 0 1", r_timeout, bq_addr.size());
        end else begin
            checks++;
            if (bq_addr[0] !== 24'h000100 || bq_len[0] !== 8'd5) begin
                errors++; $display("FAIL t6_burst got %h/%0d want 000100/5", bq_addr[0], bq_len[0]);
            end
        end
        checks++;
        if (r_words != 5 || r_dones != 1 || r_wdata_bad != 0) begin
            errors++;
            $display("FAIL t6_words got %0d/%0d/%0d want 5/1/0", r_words, r_dones, r_wdata_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_zero_count();
        test_retrigger();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
